// File: rtl/byte_stream_unpacker.sv
// byte_stream_unpacker: reassembles a byte valid/ready stream into words.
// First byte of a word lands in the most-significant lane.
// Ports:
//   i_clk, i_rst (sync, active-high), i_cg (clock-gate enable)
//   i_byte/i_byteValid/i_byteLast -> o_byteReady   byte input stream
//   o_word/o_wordValid/o_wordLast/o_wordNBytes <- i_wordReady   word output
module byte_stream_unpacker #(
    parameter int WORD_BYTES = 4,
    parameter int BYTE_W     = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_cg,
    input  logic [BYTE_W-1:0]                  i_byte,
    input  logic                               i_byteValid,
    input  logic                               i_byteLast,
    output logic                               o_byteReady,
    output logic [WORD_BYTES*BYTE_W-1:0]       o_word,
    output logic                               o_wordValid,
    output logic                               o_wordLast,
    output logic [$clog2(WORD_BYTES+1)-1:0]    o_wordNBytes,
    input  logic                               i_wordReady
);

    localparam int WW = WORD_BYTES * BYTE_W;
    localparam int NW = $clog2(WORD_BYTES + 1);
    localparam logic [NW-1:0] LAST_IDX = NW'(WORD_BYTES - 1);

    logic [WW-1:0] r_acc;
    logic [NW-1:0] r_cnt;
    logic          r_accDone;
    logic          r_accLast;
    logic [NW-1:0] r_accN;

    logic [WW-1:0] r_word;
    logic          r_wordValid;
    logic          r_wordLast;
    logic [NW-1:0] r_wordN;

    logic          w_bhs;
    logic          w_whs;
    logic          w_free;
    logic          w_done;
    logic [NW-1:0] w_n;
    logic [WW-1:0] w_fill;

    assign w_bhs  = i_byteValid & ~r_accDone & i_cg;
    assign w_whs  = r_wordValid & i_wordReady & i_cg;
    assign w_free = ~r_wordValid | w_whs;
    assign w_done = w_bhs & ((r_cnt == LAST_IDX) | i_byteLast);
    assign w_n    = r_cnt + NW'(1);

    // Accumulator with the incoming byte dropped into lane r_cnt.
    always_comb begin
        w_fill = r_acc;
        for (int j = 0; j < WORD_BYTES; j++) begin
            if (r_cnt == NW'(j)) begin
                w_fill[(WORD_BYTES-1-j)*BYTE_W +: BYTE_W] = i_byte;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_accDone   <= 1'b0;
            r_accLast   <= 1'b0;
            r_accN      <= '0;
            r_word      <= '0;
            r_wordValid <= 1'b0;
            r_wordLast  <= 1'b0;
            r_wordN     <= '0;
        end else if (i_cg) begin
            if (w_whs) begin
                r_wordValid <= 1'b0;
            end
            if (r_accDone) begin
                // Pending word drains as soon as the output frees up.
                if (w_free) begin
                    r_word      <= r_acc;
                    r_wordValid <= 1'b1;
                    r_wordLast  <= r_accLast;
                    r_wordN     <= r_accN;
                    r_accDone   <= 1'b0;
                    r_acc       <= '0;
                end
            end else if (w_bhs) begin
                if (w_done) begin
                    r_cnt <= '0;
                    if (w_free) begin
                        r_word      <= w_fill;
                        r_wordValid <= 1'b1;
                        r_wordLast  <= i_byteLast;
                        r_wordN     <= w_n;
                        r_acc       <= '0;
                    end else begin
                        r_acc     <= w_fill;
                        r_accDone <= 1'b1;
                        r_accLast <= i_byteLast;
                        r_accN    <= w_n;
                    end
                end else begin
                    r_acc <= w_fill;
                    r_cnt <= w_n;
                end
            end
        end
    end

    assign o_byteReady  = ~r_accDone;
    assign o_word       = r_word;
    assign o_wordValid  = r_wordValid;
    assign o_wordLast   = r_wordLast;
    assign o_wordNBytes = r_wordN;

endmodule

// File: tb/tb_byte_stream_unpacker.sv
// Testbench for byte_stream_unpacker: directed cases plus random traffic
// scored against a queue-based frame model.
module tb_byte_stream_unpacker;

    localparam int WB = 4;
    localparam int BW = 8;
    localparam int WW = WB * BW;
    localparam int NW = $clog2(WB + 1);

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cg = 1'b1;
    logic [BW-1:0] i_byte = '0;
    logic          i_byteValid = 1'b0;
    logic          i_byteLast = 1'b0;
    logic          o_byteReady;
    logic [WW-1:0] o_word;
    logic          o_wordValid;
    logic          o_wordLast;
    logic [NW-1:0] o_wordNBytes;
    logic          i_wordReady = 1'b1;

    byte_stream_unpacker #(.WORD_BYTES(WB), .BYTE_W(BW)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cg         (i_cg),
        .i_byte       (i_byte),
        .i_byteValid  (i_byteValid),
        .i_byteLast   (i_byteLast),
        .o_byteReady  (o_byteReady),
        .o_word       (o_word),
        .o_wordValid  (o_wordValid),
        .o_wordLast   (o_wordLast),
        .o_wordNBytes (o_wordNBytes),
        .i_wordReady  (i_wordReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] w;
        int            n;
        logic          l;
    } exp_t;

    exp_t   exp_q[$];
    int     cur[$];
    int     whs_cyc[$];
    int     cyc = 0;
    int     n_chk = 0;
    int     n_err = 0;

    logic          prev_stall = 1'b0;
    logic [WW-1:0] prev_word;
    logic          prev_last;
    logic [NW-1:0] prev_n;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame model: collect bytes, emit a word when full or on last.
    task automatic model_push(input int b, input logic l);
        exp_t e;
        logic [WW-1:0] w;
        cur.push_back(b);
        if (l || cur.size() == WB) begin
            w = '0;
            foreach (cur[j]) w = (w << BW) | WW'(cur[j]);
            w = w << (BW * (WB - cur.size()));
            e.w = w;
            e.n = cur.size();
            e.l = l;
            exp_q.push_back(e);
            cur.delete();
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (i_rst) begin
            cur.delete();
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(o_wordValid), 64'd1);
                chk("hold_word", 64'(o_word), 64'(prev_word));
                chk("hold_last", 64'(o_wordLast), 64'(prev_last));
                chk("hold_n", 64'(o_wordNBytes), 64'(prev_n));
            end
            if (i_cg && o_wordValid && i_wordReady) begin
                whs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(o_word), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 64'(o_word), 64'(e.w));
                    chk("nbytes", 64'(o_wordNBytes), 64'(e.n));
                    chk("last", 64'(o_wordLast), 64'(e.l));
                end
            end
            if (i_cg && i_byteValid && o_byteReady)
                model_push(int'(i_byte), i_byteLast);
            prev_stall = o_wordValid & ~i_wordReady;
        end
        prev_word = o_word;
        prev_last = o_wordLast;
        prev_n    = o_wordNBytes;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [BW-1:0] b, input logic l);
        int n;
        n = 0;
        i_byte = b;
        i_byteLast = l;
        i_byteValid = 1'b1;
        forever begin
            @(negedge clk);
            if (o_byteReady && i_cg) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        tick();
        i_byteValid = 1'b0;
        i_byteLast = 1'b0;
    endtask

    initial begin
        int k;
        int t;
        repeat (2) tick();
        i_rst = 1'b0;
        chk("rst_ready", 64'(o_byteReady), 64'd1);
        chk("rst_valid", 64'(o_wordValid), 64'd0);
        chk("rst_word", 64'(o_word), 64'd0);
        chk("rst_last", 64'(o_wordLast), 64'd0);
        chk("rst_n", 64'(o_wordNBytes), 64'd0);

        // Basic word, one-cycle latency.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("t1_valid", 64'(o_wordValid), 64'd1);
        chk("t1_word", 64'(o_word), 64'h11223344);
        chk("t1_n", 64'(o_wordNBytes), 64'd4);
        chk("t1_last", 64'(o_wordLast), 64'd0);
        tick();

        // 8-byte frame back to back, no gap between words.
        whs_cyc.delete();
        for (int i = 1; i <= 8; i++) send(BW'(i), i == 8);
        chk("t2_word", 64'(o_word), 64'h05060708);
        chk("t2_last", 64'(o_wordLast), 64'd1);
        tick();
        tick();
        chk("t2_nwords", 64'(whs_cyc.size()), 64'd2);
        if (whs_cyc.size() == 2)
            chk("t2_gap", 64'(whs_cyc[1] - whs_cyc[0]), 64'd4);

        // Short frame.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("t3_word", 64'(o_word), 64'hAABB0000);
        chk("t3_n", 64'(o_wordNBytes), 64'd2);
        chk("t3_last", 64'(o_wordLast), 64'd1);
        tick();

        // Stalled output: one word held, one pending, then refusal.
        i_wordReady = 1'b0;
        k = 0;
        repeat (20) begin
            i_byteValid = (k < 12);
            i_byte = BW'(8'h30 + k);
            @(negedge clk);
            if (i_byteValid && o_byteReady) k++;
            tick();
        end
        chk("t4_accepted", 64'(k), 64'd8);
        chk("t4_ready_low", 64'(o_byteReady), 64'd0);
        chk("t4_head", 64'(o_word), 64'h30313233);
        i_wordReady = 1'b1;
        t = 0;
        while (k < 12 && t < 100) begin
            i_byteValid = 1'b1;
            i_byte = BW'(8'h30 + k);
            @(negedge clk);
            if (o_byteReady) k++;
            tick();
            t++;
        end
        i_byteValid = 1'b0;
        repeat (4) tick();
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // Clock gate low mid-word: junk byte must not be taken.
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        i_cg = 1'b0;
        i_byteValid = 1'b1;
        i_byte = 8'hEE;
        repeat (3) tick();
        chk("t5_novalid", 64'(o_wordValid), 64'd0);
        i_cg = 1'b1;
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        chk("t5_word", 64'(o_word), 64'hC1C2C3C4);
        tick();

        // Reset discards a partial word.
        send(8'h99, 1'b0);
        send(8'h9A, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t6_ready", 64'(o_byteReady), 64'd1);
        chk("t6_valid", 64'(o_wordValid), 64'd0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        chk("t6_word", 64'(o_word), 64'h55667788);
        tick();

        // Random traffic with backpressure and gating.
        repeat (3000) begin
            i_byteValid = ($urandom_range(0, 3) != 0);
            i_byte = BW'($urandom);
            i_byteLast = ($urandom_range(0, 4) == 0);
            i_wordReady = ($urandom_range(0, 2) != 0);
            i_cg = ($urandom_range(0, 7) != 0);
            tick();
        end
        i_byteValid = 1'b0;
        i_byteLast = 1'b0;
        i_wordReady = 1'b1;
        i_cg = 1'b1;
        repeat (6) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
